// File: rtl/switch_game_pkg.sv
// Shared types and constants for the switch game.
// Holds the switch conditioner state encoding and board-level sizes.
package switch_game_pkg;

    localparam int SW_WIDTH      = 10;
    localparam int DEBOUNCE_50MS = 2500000;

    typedef enum logic [1:0] {
        INIT,
        IDLE,
        SETTLE,
        COMMIT
    } cond_state_t;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs.
// Both stages clear to zero on reset.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // first stage may go metastable; second stage gives it a cycle to resolve
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/switch_conditioner.sv
// Synchronises and debounces the slide switches as one word.
// Emits a one-cycle change event describing which switches flipped.
module switch_conditioner
    import switch_game_pkg::*;
#(
    parameter int WIDTH           = SW_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_50MS,
    parameter int CNT_W           = 22,
    parameter int IDX_W           = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw_stable,
    output logic             change_pulse,
    output logic [WIDTH-1:0] change_mask,
    output logic [IDX_W-1:0] change_index,
    output logic             multi_change,
    output logic             busy
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    cond_state_t      state_q, state_d;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] snap_q, snap_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       init_q, init_d;
    logic [WIDTH-1:0] stable_q, stable_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [IDX_W-1:0] index_q, index_d;
    logic             multi_q, multi_d;
    logic             pulse_q, pulse_d;

    logic [WIDTH-1:0] commit_mask;
    logic [IDX_W-1:0] commit_idx;
    logic             commit_multi;

    sync_2ff #(
        .WIDTH(WIDTH)
    ) u_sync (
        .clk    (clk),
        .reset_n(reset_n),
        .d      (sw_raw),
        .q      (sync)
    );

    assign commit_mask  = snap_q ^ stable_q;
    assign commit_multi = |(commit_mask & (commit_mask - WIDTH'(1)));

    // lowest flipped switch wins: scan high to low so low bits overwrite
    always_comb begin
        commit_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (commit_mask[i]) commit_idx = IDX_W'(i);
        end
    end

    // next-state and datapath updates for the debounce FSM
    always_comb begin
        state_d  = state_q;
        snap_d   = snap_q;
        cnt_d    = cnt_q;
        init_d   = init_q;
        stable_d = stable_q;
        mask_d   = mask_q;
        index_d  = index_q;
        multi_d  = multi_q;
        pulse_d  = 1'b0;
        unique case (state_q)
            INIT: begin
                if (init_q == 2'd2) begin
                    stable_d = sync;
                    state_d  = IDLE;
                end else begin
                    init_d = init_q + 2'd1;
                end
            end
            IDLE: begin
                if (sync != stable_q) begin
                    snap_d  = sync;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (sync == stable_q) begin
                    state_d = IDLE;
                end else if (sync != snap_q) begin
                    snap_d = sync;
                    cnt_d  = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = COMMIT;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            COMMIT: begin
                stable_d = snap_q;
                mask_d   = commit_mask;
                index_d  = commit_idx;
                multi_d  = commit_multi;
                pulse_d  = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = INIT;
        endcase
    end

    // state and output registers; reset drops any pending change
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= INIT;
            snap_q   <= '0;
            cnt_q    <= '0;
            init_q   <= '0;
            stable_q <= '0;
            mask_q   <= '0;
            index_q  <= '0;
            multi_q  <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            snap_q   <= snap_d;
            cnt_q    <= cnt_d;
            init_q   <= init_d;
            stable_q <= stable_d;
            mask_q   <= mask_d;
            index_q  <= index_d;
            multi_q  <= multi_d;
            pulse_q  <= pulse_d;
        end
    end

    assign sw_stable    = stable_q;
    assign change_pulse = pulse_q;
    assign change_mask  = mask_q;
    assign change_index = index_q;
    assign multi_change = multi_q;
    assign busy         = (state_q == INIT) || (state_q == SETTLE);

endmodule

// File: doc/switch_conditioner.md
# switch_conditioner

Upstream input stage for the switch game, placed between the raw `SW[9:0]` pins and the gameplay block. It synchronises the asynchronous slide-switch inputs and debounces them as one vector. It presents a stable switch word and emits a single-cycle change event that describes which switches flipped. Gameplay consumes `change_pulse` and `change_mask` in place of running its own per-prompt debounce counter.

## Interface
- `WIDTH`, 10: number of switches.
- `DEBOUNCE_CYCLES`, 2500000: cycles the synchronised input must hold steady before it is committed (50 ms at 50 MHz). Minimum 2.
- `CNT_W`, 22: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- `IDX_W`, 4: width of `change_index`. Must satisfy 2^IDX_W ≥ WIDTH.

Ports:
- `clk`  in  1: system clock (MAX10_CLK1_50).
- `reset_n`  in  1: asynchronous, active-low reset.
- `sw_raw`  in  WIDTH: raw switch pins, asynchronous to `clk`.
- `sw_stable`  out  WIDTH: debounced switch word.
- `change_pulse`  out  1: one-cycle strobe, asserted when `sw_stable` updates.
- `change_mask`  out  WIDTH: old `sw_stable` XOR new `sw_stable`. Held until the next commit.
- `change_index`  out  IDX_W: index of the lowest set bit of `change_mask`. Held until the next commit.
- `multi_change`  out  1: `change_mask` has more than one bit set. Held until the next commit.
- `busy`  out  1: high in INIT and SETTLE.

## Operation
- **Synchroniser:** `sw_raw` passes through two flops per bit to give `sync`. No other logic reads `sw_raw`.
- **INIT:** entered on reset.
  - Waits 2 cycles for the synchroniser to fill.
  - Then loads `sw_stable <= sync` with no `change_pulse`, and goes to IDLE.
- **IDLE:**
  - If `sync != sw_stable`: `snap <= sync`, `cnt <= 0`, go to SETTLE.
  - Otherwise stay in IDLE.
- **SETTLE** (conditions are checked in this order):
  - If `sync == sw_stable`: the bounce returned to the old value. Go to IDLE with no event.
  - Else if `sync != snap`: `snap <= sync`, `cnt <= 0`, stay in SETTLE.
  - Else if `cnt == DEBOUNCE_CYCLES-1`: go to COMMIT.
  - Else `cnt <= cnt+1`.
- **COMMIT** (one cycle):
  - `sw_stable <= snap`.
  - `change_mask <= snap ^ sw_stable`.
  - `change_index` and `multi_change` are computed from that mask.
  - `change_pulse` is high for exactly this one cycle. Next state is IDLE.
- **Arithmetic rules:**
  - `change_index` is a priority encode of the mask, lowest bit wins.
  - `multi_change` is true when popcount > 1, implemented as `mask & (mask-1) != 0`.
  - `cnt` never wraps. It saturates at DEBOUNCE_CYCLES-1 by construction.
- **Simultaneous switch flips:** switches that flip within one settle window commit together as one event with `multi_change=1`. Gameplay treats `multi_change` as a wrong answer.

## Timing
- **Reset values** (all outputs): `sw_stable=0`, `change_pulse=0`, `change_mask=0`, `change_index=0`, `multi_change=0`, `busy=1`. State is INIT.
- **Reset mid-SETTLE:** the pending change is discarded and no pulse is emitted. After INIT, `sw_stable` reflects the current pins.
- **Latency:** let edge E be the first edge where `sync` differs from `sw_stable`.
  - SETTLE is entered at E+1.
  - COMMIT is entered at E+1+DEBOUNCE_CYCLES.
  - `sw_stable` and `change_pulse` are valid after edge E+2+DEBOUNCE_CYCLES.
  - Raw pin to stable: roughly DEBOUNCE_CYCLES+4 cycles.
- **Back-to-back changes:** `change_pulse` is never high on two consecutive cycles. The minimum spacing between pulses is DEBOUNCE_CYCLES+2 cycles.
- **Handshake:** there is no ready/ack. The consumer must sample `change_pulse` every cycle, and the `change_*` outputs are stable at least until the next pulse.

## Structure
- The shared package `switch_game_pkg` holds:
  - the state enum (INIT, IDLE, SETTLE, COMMIT);
  - `SW_WIDTH=10`;
  - `DEBOUNCE_50MS=2500000`.
- One sub-module, `sync_2ff`: a parameterised-width two-flop synchroniser with async active-low reset to 0.
- The priority encoder and the popcount>1 check stay inline as combinational logic.

## Test plan
All scenarios run with `DEBOUNCE_CYCLES=4`.
- **Reset/init:** hold `sw_raw=10'h2A5` through a reset release. Expect `busy=1` for 3 cycles, then `sw_stable=10'h2A5`, `busy=0`, and no `change_pulse`.
- **Single flip:** from `10'h000`, set bit 3 and hold. Expect exactly one pulse at E+6 with `sw_stable=10'h008`, `change_mask=10'h008`, `change_index=3`, `multi_change=0`.
- **Bounce:** toggle bit 7 as 1,0,1,0 at 1-cycle intervals, then return to 0. Expect no pulse and `sw_stable` unchanged. Then hold bit 7 at 1: expect one pulse, timed from the last toggle.
- **Multi flip:** flip bits 2 and 9 one cycle apart inside the window. Expect one pulse with `change_mask=10'h204`, `change_index=2`, `multi_change=1`.
- **Reset mid-settle:** flip bit 0, then assert `reset_n=0` two cycles into SETTLE. Expect no pulse and all outputs at reset values. After release, `sw_stable=10'h001` with no pulse.
- **Back-to-back:** flip bit 1, and once its pulse is seen, immediately flip bit 4. Expect two pulses separated by at least 6 cycles, with `change_index` 1 then 4.
